// File: rtl/sm83_dbg_pkg.sv
// Shared constants and types for the SM83 debug interface: host command opcodes,
// response codes and the controller state encoding.
package sm83_dbg_pkg;

    localparam logic [7:0] CMD_NOP  = 8'h00;
    localparam logic [7:0] CMD_HALT = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;
    localparam logic [7:0] CMD_READ = 8'h04;
    localparam logic [7:0] CMD_EXEC = 8'h05;

    localparam logic [7:0] RSP_HALT = 8'h01;
    localparam logic [7:0] RSP_STEP = 8'h03;
    localparam logic [7:0] RSP_EXEC = 8'h05;

    localparam int READ_LEN = 9;
    localparam int FRAME_W  = 8 * READ_LEN;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_HALT,
        ST_STEP_RUN,
        ST_EXEC_ARG,
        ST_SEND
    } state_t;

    // What to do at the next M-cycle boundary once in ST_WAIT_HALT.
    typedef enum logic [1:0] {
        MODE_HALT,
        MODE_RUN,
        MODE_STEP,
        MODE_EXEC
    } mode_t;

endpackage

// File: rtl/sm83_dbg_if.sv
// Host byte link: rx and tx each carry a data byte plus a toggling sequence bit.
// Handshake: a byte is new while its seq differs from the peer's ack; the
// receiver consumes it by copying seq into ack, and the sender may only change
// data/seq again once ack equals seq.
interface sm83_dbg_if;
    logic [7:0] data_rx;
    logic       data_rx_valid;
    logic       data_rx_seq;
    logic       data_rx_ack;
    logic [7:0] data_tx;
    logic       data_tx_seq;
    logic       data_tx_ack;

    modport master (
        output data_rx, data_rx_valid, data_rx_seq, data_tx_ack,
        input  data_rx_ack, data_tx, data_tx_seq
    );

    modport slave (
        input  data_rx, data_rx_valid, data_rx_seq, data_tx_ack,
        output data_rx_ack, data_tx, data_tx_seq
    );
endinterface

// File: rtl/sm83_dbg_tx.sv
// Response serializer: holds a READ frame or a single ack byte and hands bytes
// to the host one at a time, least significant byte of the buffer first.
module sm83_dbg_tx
    import sm83_dbg_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_frame_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic               load_one_i,
    input  logic [7:0]         one_i,
    input  logic               tx_ack_i,
    output logic [7:0]         data_tx_o,
    output logic               tx_seq_o,
    output logic               pending_o
);
    logic [FRAME_W-1:0] buf_q, buf_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         data_q, data_d;
    logic               seq_q, seq_d;

    always_comb begin
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        seq_d  = seq_q;
        if (load_frame_i) begin
            buf_d = frame_i;
            cnt_d = 4'(READ_LEN);
        end else if (load_one_i) begin
            buf_d = {{(FRAME_W-8){1'b0}}, one_i};
            cnt_d = 4'd1;
        end else if (cnt_q != 4'd0 && tx_ack_i == seq_q) begin
            // Previous byte has been echoed back, so the next one may go out.
            data_d = buf_q[7:0];
            buf_d  = {8'h00, buf_q[FRAME_W-1:8]};
            cnt_d  = cnt_q - 4'd1;
            seq_d  = ~seq_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_q  <= '0;
            cnt_q  <= 4'd0;
            data_q <= 8'h00;
            seq_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            seq_q  <= seq_d;
        end
    end

    assign data_tx_o = data_q;
    assign tx_seq_o  = seq_q;
    assign pending_o = (cnt_q != 4'd0);

endmodule

// File: rtl/sm83_dbg_ifc.sv
// SM83 debug controller: decodes host commands, halts/steps the CPU on M-cycle
// boundaries, injects EXEC opcodes onto the data bus and streams register snapshots.
module sm83_dbg_ifc
    import sm83_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ncyc,
    input  logic        phi,
    input  logic        p_rd,
    input  logic [15:0] adr,
    input  logic [15:0] pc,
    input  logic [15:0] wz,
    input  logic [15:0] sp,
    input  logic [3:0]  f,
    input  logic        ime,
    input  logic [7:0]  probe,
    sm83_dbg_if.slave   host,
    output logic [7:0]  data,
    output logic        drv,
    output logic        halt,
    output logic        no_inc,
    output state_t      dbg_state_o
);
    state_t     state_q, state_d;
    mode_t      mode_q, mode_d;
    logic       halt_q, halt_d;
    logic [7:0] data_q, data_d;
    logic       rx_ack_q, rx_ack_d;

    logic               rx_new;
    logic               load_frame, load_one;
    logic [7:0]         one_byte;
    logic               tx_pending;
    logic [FRAME_W-1:0] frame;

    // Phase clock and upper address byte are not needed by the controller.
    logic unused_in;
    assign unused_in = ^{phi, adr[15:8]};

    assign rx_new = host.data_rx_valid && (host.data_rx_seq != rx_ack_q);
    assign frame  = {adr[7:0], probe, f, 3'b000, ime, wz, sp, pc};

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        halt_d     = halt_q;
        data_d     = data_q;
        rx_ack_d   = rx_ack_q;
        load_frame = 1'b0;
        load_one   = 1'b0;
        one_byte   = 8'h00;
        case (state_q)
            ST_IDLE: if (rx_new) begin
                rx_ack_d = host.data_rx_seq;
                case (host.data_rx)
                    CMD_NOP: ;
                    CMD_HALT: if (halt_q) begin
                        load_one = 1'b1;
                        one_byte = RSP_HALT;
                        state_d  = ST_SEND;
                    end else begin
                        mode_d  = MODE_HALT;
                        state_d = ST_WAIT_HALT;
                    end
                    CMD_RUN: begin
                        mode_d  = MODE_RUN;
                        state_d = ST_WAIT_HALT;
                    end
                    CMD_STEP: if (halt_q) begin
                        mode_d  = MODE_STEP;
                        state_d = ST_WAIT_HALT;
                    end
                    CMD_READ: begin
                        load_frame = 1'b1;
                        state_d    = ST_SEND;
                    end
                    CMD_EXEC: state_d = ST_EXEC_ARG;
                    default: ;
                endcase
            end
            // Halt cannot change while waiting for the operand, so halt_q still
            // reflects the state at the time the EXEC opcode arrived.
            ST_EXEC_ARG: if (rx_new) begin
                rx_ack_d = host.data_rx_seq;
                if (halt_q) begin
                    data_d  = host.data_rx;
                    mode_d  = MODE_EXEC;
                    state_d = ST_WAIT_HALT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_HALT: if (ncyc) begin
                case (mode_q)
                    MODE_HALT: begin
                        halt_d   = 1'b1;
                        load_one = 1'b1;
                        one_byte = RSP_HALT;
                        state_d  = ST_SEND;
                    end
                    MODE_RUN: begin
                        halt_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                    default: begin
                        halt_d  = 1'b0;
                        state_d = ST_STEP_RUN;
                    end
                endcase
            end
            ST_STEP_RUN: if (ncyc) begin
                halt_d   = 1'b1;
                load_one = 1'b1;
                one_byte = (mode_q == MODE_EXEC) ? RSP_EXEC : RSP_STEP;
                state_d  = ST_SEND;
            end
            ST_SEND: if (!tx_pending) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_HALT;
            halt_q   <= 1'b0;
            data_q   <= 8'h00;
            rx_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            halt_q   <= halt_d;
            data_q   <= data_d;
            rx_ack_q <= rx_ack_d;
        end
    end

    sm83_dbg_tx u_tx (
        .clk          (clk),
        .reset        (reset),
        .load_frame_i (load_frame),
        .frame_i      (frame),
        .load_one_i   (load_one),
        .one_i        (one_byte),
        .tx_ack_i     (host.data_tx_ack),
        .data_tx_o    (host.data_tx),
        .tx_seq_o     (host.data_tx_seq),
        .pending_o    (tx_pending)
    );

    assign host.data_rx_ack = rx_ack_q;
    assign halt             = halt_q;
    assign data             = data_q;
    assign no_inc           = (state_q == ST_STEP_RUN) && (mode_q == MODE_EXEC);
    assign drv              = no_inc && p_rd;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_sm83_dbg_ifc.sv
// Bench for sm83_dbg_ifc: directed and random host commands checked against a
// command-level reference model of halt state and expected response bytes.
module tb_sm83_dbg_ifc;
    import sm83_dbg_pkg::*;

    localparam int NCYC_PER = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ncyc, phi, p_rd;
    logic [15:0] adr, pc, wz, sp;
    logic [3:0]  f;
    logic        ime;
    logic [7:0]  probe;
    logic [7:0]  data;
    logic        drv, halt, no_inc;
    state_t      dbg_state;

    sm83_dbg_if host_if();

    sm83_dbg_ifc dut (
        .clk         (clk),
        .reset       (reset),
        .ncyc        (ncyc),
        .phi         (phi),
        .p_rd        (p_rd),
        .adr         (adr),
        .pc          (pc),
        .wz          (wz),
        .sp          (sp),
        .f           (f),
        .ime         (ime),
        .probe       (probe),
        .host        (host_if),
        .data        (data),
        .drv         (drv),
        .halt        (halt),
        .no_inc      (no_inc),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         ref_halted = 1'b0;
    bit         auto_ack   = 1'b1;
    logic [7:0] exec_arg   = 8'h00;
    int         pc_incs = 0, halt_low_cyc = 0, noinc_cyc = 0, drv_cyc = 0, mon_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CPU stand-in: M-cycle strobe every NCYC_PER clocks, bus read in the first
    // two clocks of each M-cycle, PC advances per completed unhalted M-cycle.
    initial begin : cpu_model
        int k;
        k = 0; ncyc = 1'b0; p_rd = 1'b0; phi = 1'b0;
        forever begin
            @(negedge clk);
            k++;
            if ((k % NCYC_PER) == NCYC_PER - 1 && halt === 1'b0 && no_inc === 1'b0)
                pc_incs++;
            ncyc = ((k % NCYC_PER) == NCYC_PER - 1);
            p_rd = ((k % NCYC_PER) < 2);
            phi  = k[0];
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (halt === 1'b0) halt_low_cyc++;
            if (drv === 1'b1) drv_cyc++;
            if (no_inc === 1'b1) begin
                noinc_cyc++;
                if (drv !== p_rd || data !== exec_arg) mon_err++;
            end else if (drv !== 1'b0 && reset === 1'b1) begin
                mon_err++;
            end
        end
    end

    initial begin : host_receiver
        host_if.data_tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset !== 1'b1) begin
                host_if.data_tx_ack = 1'b0;
            end else if (auto_ack && host_if.data_tx_seq !== host_if.data_tx_ack) begin
                got_q.push_back(host_if.data_tx);
                host_if.data_tx_ack = host_if.data_tx_seq;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic post(input logic [7:0] b);
        host_if.data_rx       = b;
        host_if.data_rx_valid = 1'b1;
        host_if.data_rx_seq   = ~host_if.data_rx_seq;
    endtask

    task automatic wait_rx_ack(input string tag);
        int t;
        t = 0;
        while (host_if.data_rx_ack !== host_if.data_rx_seq && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(host_if.data_rx_ack), 32'(host_if.data_rx_seq));
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        post(b);
        wait_rx_ack(tag);
    endtask

    task automatic drain(input string tag);
        int t;
        logic [7:0] e, g;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            chk(tag, 32'(g), 32'(e));
        end
        got_q.delete();
    endtask

    task automatic randomize_regs();
        pc = 16'($urandom); sp = 16'($urandom); wz = 16'($urandom); adr = 16'($urandom);
        f = 4'($urandom); ime = 1'($urandom); probe = 8'($urandom);
    endtask

    function automatic void model_read();
        exp_q.push_back(pc[7:0]);  exp_q.push_back(pc[15:8]);
        exp_q.push_back(sp[7:0]);  exp_q.push_back(sp[15:8]);
        exp_q.push_back(wz[7:0]);  exp_q.push_back(wz[15:8]);
        exp_q.push_back({f, 3'b000, ime});
        exp_q.push_back(probe);
        exp_q.push_back(adr[7:0]);
    endfunction

    // Reference behaviour of one command at the host level.
    function automatic void model_cmd(input logic [7:0] cmd);
        case (cmd)
            8'h01: begin ref_halted = 1'b1; exp_q.push_back(8'h01); end
            8'h02: ref_halted = 1'b0;
            8'h03: if (ref_halted) exp_q.push_back(8'h03);
            8'h04: model_read();
            8'h05: if (ref_halted) exp_q.push_back(8'h05);
            default: ;
        endcase
    endfunction

    initial begin : main
        logic [7:0] frame_c [9];
        logic [7:0] cmd, arg;
        logic       s_exp;
        int         p0, n0, d0, h0, m0;

        frame_c = '{8'h04, 8'h00, 8'hFE, 8'hFF, 8'h34, 8'h12, 8'h81, 8'h3C, 8'h04};
        reset = 1'b0;
        host_if.data_rx = 8'h00; host_if.data_rx_valid = 1'b0; host_if.data_rx_seq = 1'b0;
        pc = 16'h0; sp = 16'h0; wz = 16'h0; adr = 16'h0; f = 4'h0; ime = 1'b0; probe = 8'h0;
        cycles(3);
        chk("rst halt", 32'(halt), 32'd0);
        chk("rst drv", 32'(drv), 32'd0);
        chk("rst no_inc", 32'(no_inc), 32'd0);
        chk("rst data", 32'(data), 32'h00);
        chk("rst data_tx", 32'(host_if.data_tx), 32'h00);
        chk("rst tx_seq", 32'(host_if.data_tx_seq), 32'd0);
        chk("rst rx_ack", 32'(host_if.data_rx_ack), 32'd0);
        chk("rst state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b1;
        cycles(2);

        // HALT from running
        send(8'h01, "halt cmd ack");
        chk("halt rx_ack", 32'(host_if.data_rx_ack), 32'd1);
        model_cmd(8'h01);
        drain("halt rsp");
        chk("halt level", 32'(halt), 32'd1);
        chk("halt tx_seq", 32'(host_if.data_tx_seq), 32'd1);

        // READ with fixed register values, inputs scrambled after consumption
        pc = 16'h0004; sp = 16'hFFFE; wz = 16'h1234; f = 4'b1000; ime = 1'b1;
        probe = 8'h3C; adr = 16'h0004;
        foreach (frame_c[i]) exp_q.push_back(frame_c[i]);
        send(8'h04, "read cmd ack");
        randomize_regs();
        drain("read fixed");

        for (int i = 0; i < 3; i++) begin
            randomize_regs();
            model_cmd(8'h04);
            send(8'h04, "read rnd ack");
            randomize_regs();
            drain("read rnd");
        end

        // EXEC while halted
        p0 = pc_incs; n0 = noinc_cyc; d0 = drv_cyc; h0 = halt_low_cyc; m0 = mon_err;
        exec_arg = 8'h3C;
        send(8'h05, "exec cmd ack");
        send(8'h3C, "exec arg ack");
        model_cmd(8'h05);
        drain("exec rsp");
        chk("exec halt", 32'(halt), 32'd1);
        chk("exec no_inc cycles", 32'(noinc_cyc - n0), 32'(NCYC_PER));
        chk("exec drv cycles", 32'(drv_cyc - d0), 32'd2);
        chk("exec halt low cycles", 32'(halt_low_cyc - h0), 32'(NCYC_PER));
        chk("exec bus errors", 32'(mon_err - m0), 32'd0);
        chk("exec pc unchanged", 32'(pc_incs - p0), 32'd0);
        chk("exec data held", 32'(data), 32'h3C);

        // STEP while halted
        p0 = pc_incs; n0 = noinc_cyc; h0 = halt_low_cyc;
        send(8'h03, "step cmd ack");
        model_cmd(8'h03);
        drain("step rsp");
        chk("step halt low cycles", 32'(halt_low_cyc - h0), 32'(NCYC_PER));
        chk("step pc advance", 32'(pc_incs - p0), 32'd1);
        chk("step no_inc cycles", 32'(noinc_cyc - n0), 32'd0);
        chk("step halt", 32'(halt), 32'd1);

        // RUN, then STEP and EXEC while running are ignored
        send(8'h02, "run cmd ack");
        model_cmd(8'h02);
        cycles(2 * NCYC_PER);
        chk("run halt low", 32'(halt), 32'd0);
        d0 = drv_cyc;
        send(8'h03, "step running ack");
        send(8'h05, "exec running ack");
        send(8'h77, "exec running arg ack");
        cycles(3 * NCYC_PER);
        chk("running halt low", 32'(halt), 32'd0);
        chk("running no drv", 32'(drv_cyc - d0), 32'd0);
        chk("running no rsp", 32'(got_q.size()), 32'd0);

        // Random command stream against the reference model
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 6))
                0: cmd = 8'h00;
                1: cmd = 8'h01;
                2: cmd = 8'h02;
                3: cmd = 8'h03;
                4: cmd = 8'h04;
                5: cmd = 8'h05;
                default: cmd = 8'($urandom_range(6, 255));
            endcase
            arg = 8'($urandom);
            if (cmd == 8'h04) randomize_regs();
            if (cmd == 8'h05) exec_arg = arg;
            p0 = ref_halted ? 1 : 0;
            model_cmd(cmd);
            send(cmd, "rnd cmd ack");
            if (cmd == 8'h05) send(arg, "rnd arg ack");
            drain("rnd rsp");
            if (cmd == 8'h01 || ((cmd == 8'h03 || cmd == 8'h05) && p0 == 1))
                chk("rnd halt", 32'(halt), 32'd1);
            if (cmd == 8'h05 && p0 == 1)
                chk("rnd exec data", 32'(data), 32'(arg));
        end
        cycles(2 * NCYC_PER);

        // Back-pressure: withhold tx acks during a READ frame
        auto_ack = 1'b0;
        cycles(2);
        s_exp = ~host_if.data_tx_seq;
        randomize_regs();
        model_cmd(8'h04);
        send(8'h04, "bp read ack");
        cycles(20);
        chk("bp data_tx byte0", 32'(host_if.data_tx), 32'(exp_q[0]));
        chk("bp single toggle", 32'(host_if.data_tx_seq), 32'(s_exp));
        post(8'hAA);
        s_exp = ~host_if.data_rx_seq;
        cycles(20);
        chk("bp rx held", 32'(host_if.data_rx_ack), 32'(s_exp));
        chk("bp state send", 32'(dbg_state), 32'(ST_SEND));
        auto_ack = 1'b1;
        wait_rx_ack("bp 0xAA acked");
        drain("bp frame");
        cycles(20);
        chk("no rsp to 0xAA", 32'(got_q.size()), 32'd0);

        // Reset in the middle of a READ frame
        auto_ack = 1'b0;
        randomize_regs();
        send(8'h04, "rst read ack");
        cycles(3);
        reset = 1'b0;
        host_if.data_rx_seq = 1'b0;
        host_if.data_rx_valid = 1'b0;
        cycles(2);
        chk("midrst data_tx", 32'(host_if.data_tx), 32'h00);
        chk("midrst tx_seq", 32'(host_if.data_tx_seq), 32'd0);
        chk("midrst rx_ack", 32'(host_if.data_rx_ack), 32'd0);
        chk("midrst state", 32'(dbg_state), 32'(ST_IDLE));
        chk("midrst halt", 32'(halt), 32'd0);
        reset = 1'b1;
        exp_q.delete();
        got_q.delete();
        ref_halted = 1'b0;
        cycles(20);
        chk("postrst tx_seq quiet", 32'(host_if.data_tx_seq), 32'd0);
        chk("postrst data_tx quiet", 32'(host_if.data_tx), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
